// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem request, registered decode output
// with a one-entry skid buffer, and kill-based squashing of responses on redirect.
module instr_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        kill_q, kill_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        accept_s;
    logic        resp_s;

    // Request side decodes straight from state flops; gated by rst_i so nothing is requested in reset.
    always_comb begin
        imem_req_o  = rst_i && (state_q == ST_REQ) && !skid_valid_q;
        imem_addr_o = pc_q;
        accept_s    = imem_req_o && imem_ready_i;
        resp_s      = (state_q == ST_WAIT) && imem_rvalid_i;
    end

    // Next-state logic for the FSM, pc, kill flag, output register and skid register.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_addr_d    = out_addr_q;
        kill_d        = kill_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;

        case (state_q)
            ST_REQ: begin
                if (accept_s) begin
                    state_d    = ST_WAIT;
                    out_addr_d = pc_q;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect_i) begin
            // A same-cycle response is simply dropped; kill only guards a request still in flight.
            pc_d          = redirect_pc_i & 32'hFFFF_FFFC;
            instr_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
            kill_d        = accept_s || ((state_q == ST_WAIT) && !imem_rvalid_i);
        end else begin
            if (accept_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end

            if (instr_valid_q && id_ready_i) begin
                if (skid_valid_q) begin
                    instr_d      = skid_instr_q;
                    pc_out_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end else begin
                instr_valid_d = instr_valid_q;
            end

            if (resp_s) begin
                if (kill_q) begin
                    kill_d = 1'b0;
                end else if (!instr_valid_q || id_ready_i) begin
                    instr_d       = imem_rdata_i;
                    pc_out_d      = out_addr_q;
                    instr_valid_d = 1'b1;
                end else begin
                    skid_instr_d = imem_rdata_i;
                    skid_pc_d    = out_addr_q;
                    skid_valid_d = 1'b1;
                end
            end else begin
                kill_d = kill_q;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_REQ;
            pc_q          <= 32'd0;
            out_addr_q    <= 32'd0;
            kill_q        <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= 32'd0;
            skid_pc_q     <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'd0;
            pc_out_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_addr_q    <= out_addr_d;
            kill_q        <= kill_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;

endmodule
